// File: rtl/master_port_pkg.sv
// Shared types and constants for the bit-serial bus master port.
package master_port_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_ADDR,
        ST_WDATA,
        ST_RWAIT,
        ST_RDATA,
        ST_DONE
    } state_e;

    localparam logic MODE_READ  = 1'b0;
    localparam logic MODE_WRITE = 1'b1;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/master_port_burst_bus_shift_reg.sv
// LSB-first shift register with bit counter; used for the address, write-data
// and read-data serialisers of master_port_burst.
module bus_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_shift,
    input  logic             i_bit_in,
    output logic [WIDTH-1:0] o_data,
    output logic             o_last
);
    import master_port_pkg::*;

    localparam int CNT_W = cnt_width(WIDTH);

    logic [WIDTH-1:0] r_data;
    logic [CNT_W-1:0] r_cnt;
    logic             w_last;

    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, whatever the block order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_data <= '0;
            r_cnt  <= '0;
        end else if (i_load) begin
            r_data <= i_load_val;
            r_cnt  <= '0;
        end else if (i_shift) begin
            r_data <= {i_bit_in, r_data[WIDTH-1:1]};
            r_cnt  <= w_last ? '0 : r_cnt + 1'b1;
        end
    end

    assign o_data = r_data;
    assign o_last = w_last;

endmodule

// File: rtl/master_port_burst.sv
// Bit-serial system-bus master port with multi-beat bursts.
// Optional handshake timeout: define MASTER_PORT_TIMEOUT_EN.
module master_port_burst #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 16,
    parameter int BURST_W     = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               m_start,
    input  logic               m_mode,
    input  logic [ADDR_W-1:0]  m_addr,
    input  logic [BURST_W-1:0] m_burst_len,
    input  logic [DATA_W-1:0]  m_wr_data,
    output logic               m_wr_req,
    output logic [DATA_W-1:0]  m_rd_data,
    output logic               m_rd_valid,
    output logic               m_busy,
    output logic               m_done,
    output logic               m_error,
    output logic               mode,
    output logic               wr_bus,
    input  logic               rd_bus,
    output logic               master_valid,
    input  logic               slave_ready,
    output logic               master_ready,
    input  logic               slave_valid
);
    import master_port_pkg::*;

    if (DATA_W < 2 || ADDR_W < 2 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("master_port_burst: DATA_W/ADDR_W must be >= 2 and TIMEOUT_CYC >= 1");
    end

    state_e              r_state;
    state_e              w_next;
    logic                r_mode;
    logic [BURST_W-1:0]  r_beats_left;
    logic [DATA_W-1:0]   r_rd_data;
    logic                r_rd_valid;

    logic                w_start;
    logic                w_final_beat;
    logic                w_wr_req;
    logic                w_rd_done;
    logic                w_timeout;
    logic [ADDR_W-1:0]   w_addr_word;
    logic [DATA_W-1:0]   w_wd_word;
    logic [DATA_W-1:0]   w_rd_word;
    logic                w_addr_last;
    logic                w_wd_last;
    logic                w_rd_last;
    logic                w_unused_bits;

    assign w_start      = (r_state == ST_IDLE) && m_start;
    assign w_final_beat = (r_beats_left == '0);
    assign w_wr_req     = (r_state == ST_WDATA) && w_wd_last && !w_final_beat;
    assign w_rd_done    = (r_state == ST_RDATA) && w_rd_last;

    bus_shift_reg #(.WIDTH(ADDR_W)) u_addr_sr (
        .clk        (clk),
        .rstn       (rstn),
        .i_load     (w_start),
        .i_load_val (m_addr),
        .i_shift    (r_state == ST_ADDR),
        .i_bit_in   (1'b0),
        .o_data     (w_addr_word),
        .o_last     (w_addr_last)
    );

    // Beat 0 comes with m_start; later beats reload on the m_wr_req edge.
    bus_shift_reg #(.WIDTH(DATA_W)) u_wdata_sr (
        .clk        (clk),
        .rstn       (rstn),
        .i_load     ((w_start && (m_mode == MODE_WRITE)) || w_wr_req),
        .i_load_val (m_wr_data),
        .i_shift    (r_state == ST_WDATA),
        .i_bit_in   (1'b0),
        .o_data     (w_wd_word),
        .o_last     (w_wd_last)
    );

    bus_shift_reg #(.WIDTH(DATA_W)) u_rdata_sr (
        .clk        (clk),
        .rstn       (rstn),
        .i_load     (w_start),
        .i_load_val ({DATA_W{1'b0}}),
        .i_shift    (((r_state == ST_RWAIT) && slave_valid) || (r_state == ST_RDATA)),
        .i_bit_in   (rd_bus),
        .o_data     (w_rd_word),
        .o_last     (w_rd_last)
    );

    assign w_unused_bits = &{1'b0, w_addr_word[ADDR_W-1:1], w_wd_word[DATA_W-1:1], w_rd_word[0]};

`ifdef MASTER_PORT_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TO_W-1:0] r_to_cnt;
    logic            r_error;
    logic            w_waiting;
    logic            w_handshake;

    assign w_waiting   = (r_state == ST_REQ) || (r_state == ST_RWAIT);
    assign w_handshake = ((r_state == ST_REQ) && slave_ready) ||
                         ((r_state == ST_RWAIT) && slave_valid);
    assign w_timeout   = w_waiting && !w_handshake && (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));

    // Counter only advances while stalled; any other cycle restarts it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_to_cnt <= '0;
            r_error  <= 1'b0;
        end else begin
            r_error  <= w_timeout;
            r_to_cnt <= (w_waiting && !w_handshake) ? r_to_cnt + 1'b1 : '0;
        end
    end

    assign m_error = r_error;
`else
    assign w_timeout = 1'b0;
    assign m_error   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= ST_IDLE;
            r_mode       <= MODE_READ;
            r_beats_left <= '0;
            r_rd_data    <= '0;
            r_rd_valid   <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_rd_valid <= w_rd_done;
            if (w_start) begin
                r_mode       <= m_mode;
                r_beats_left <= m_burst_len;
            end else if (w_wr_req || (w_rd_done && !w_final_beat)) begin
                r_beats_left <= r_beats_left - 1'b1;
            end
            if (w_rd_done) begin
                r_rd_data <= {rd_bus, w_rd_word[DATA_W-1:1]};
            end
        end
    end

    // NOTE: next state defaults to the current state before the case so that
    // no path leaves w_next unassigned and no latch is inferred.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (m_start) w_next = ST_REQ;
            end
            ST_REQ: begin
                if (slave_ready)    w_next = ST_ADDR;
                else if (w_timeout) w_next = ST_DONE;
            end
            ST_ADDR: begin
                if (w_addr_last) w_next = (r_mode == MODE_WRITE) ? ST_WDATA : ST_RWAIT;
            end
            ST_WDATA: begin
                if (w_wd_last && w_final_beat) w_next = ST_DONE;
            end
            ST_RWAIT: begin
                if (slave_valid)    w_next = ST_RDATA;
                else if (w_timeout) w_next = ST_DONE;
            end
            ST_RDATA: begin
                if (w_rd_last) w_next = w_final_beat ? ST_DONE : ST_RWAIT;
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    assign m_busy       = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign m_done       = (r_state == ST_DONE);
    assign master_valid = (r_state == ST_REQ) || (r_state == ST_ADDR) || (r_state == ST_WDATA);
    assign master_ready = (r_state == ST_RWAIT) || (r_state == ST_RDATA);
    assign wr_bus       = ((r_state == ST_ADDR)  && w_addr_word[0]) ||
                          ((r_state == ST_WDATA) && w_wd_word[0]);
    assign m_wr_req     = w_wr_req;
    assign m_rd_data    = r_rd_data;
    assign m_rd_valid   = r_rd_valid;
    assign mode         = r_mode;

endmodule

// File: tb/tb_master_port_burst.sv
// Randomised self-checking bench for master_port_burst; the expected bus
// traffic and timing are derived from transaction-level arithmetic.
module tb_master_port_burst;
    import master_port_pkg::*;

    localparam int DATA_W      = 8;
    localparam int ADDR_W      = 16;
    localparam int BURST_W     = 4;
    localparam int TIMEOUT_CYC = 64;
    localparam int MAX_BEATS   = 1 << BURST_W;

    logic               clk = 1'b0;
    logic               rstn = 1'b0;
    logic               m_start = 1'b0;
    logic               m_mode = 1'b0;
    logic [ADDR_W-1:0]  m_addr = '0;
    logic [BURST_W-1:0] m_burst_len = '0;
    logic [DATA_W-1:0]  m_wr_data = '0;
    logic               m_wr_req;
    logic [DATA_W-1:0]  m_rd_data;
    logic               m_rd_valid;
    logic               m_busy;
    logic               m_done;
    logic               m_error;
    logic               mode;
    logic               wr_bus;
    logic               rd_bus = 1'b0;
    logic               master_valid;
    logic               slave_ready = 1'b0;
    logic               master_ready;
    logic               slave_valid = 1'b0;

    master_port_burst #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_W(BURST_W), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .rstn(rstn), .m_start(m_start), .m_mode(m_mode), .m_addr(m_addr),
        .m_burst_len(m_burst_len), .m_wr_data(m_wr_data), .m_wr_req(m_wr_req),
        .m_rd_data(m_rd_data), .m_rd_valid(m_rd_valid), .m_busy(m_busy), .m_done(m_done),
        .m_error(m_error), .mode(mode), .wr_bus(wr_bus), .rd_bus(rd_bus),
        .master_valid(master_valid), .slave_ready(slave_ready),
        .master_ready(master_ready), .slave_valid(slave_valid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Current transaction description (filled by the caller of run_txn).
    logic              t_mode;
    logic [ADDR_W-1:0] t_addr;
    logic [BURST_W-1:0] t_len;
    logic [DATA_W-1:0] t_words [MAX_BEATS];
    int                t_req_wait;
    int                t_gaps [MAX_BEATS];
    bit                t_silent;

    function automatic logic [16:0] all_outputs();
        return {m_wr_req, m_rd_valid, m_busy, m_done, m_error, mode, wr_bus,
                master_valid, master_ready, m_rd_data};
    endfunction

    task automatic run_txn(input string name);
        int cyc = 0;
        int req_len = t_req_wait + 1;
        int nb = int'(t_len) + 1;
        int done_cyc = -1;
        int mv_cnt = 0, idle_wb = 0, req_noise = 0, wreq_cnt = 0, first_wreq = -1;
        int busy_cnt = 0, mr_in_write = 0, wr_idx = 1;
        int sl_beat = 0, sl_bit = 0, sl_gap = 0;
        bit sl_active = 0;
        int s, exp_done, exp_mv;
        logic [ADDR_W-1:0] obs_addr = '0;
        logic [DATA_W-1:0] obs_w [MAX_BEATS];
        logic [DATA_W-1:0] obs_rd [$];
        logic [3:0] done_flags = '0;

        for (int k = 0; k < MAX_BEATS; k++) obs_w[k] = '0;

        @(negedge clk);
        m_start = 1'b1; m_mode = t_mode; m_addr = t_addr; m_burst_len = t_len;
        m_wr_data = t_words[0]; slave_ready = 1'b0; slave_valid = 1'b0; rd_bus = 1'b0;

        while (done_cyc < 0 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (master_valid) mv_cnt++;
            if (!master_valid && wr_bus) idle_wb++;
            if (cyc <= req_len && wr_bus) req_noise++;
            if (m_busy) busy_cnt++;
            if (t_mode == MODE_WRITE && master_ready) mr_in_write++;
            s = cyc - req_len - 1;
            if (s >= 0 && s < ADDR_W) obs_addr[s] = wr_bus;
            s = cyc - req_len - ADDR_W - 1;
            if (t_mode == MODE_WRITE && s >= 0 && s < nb * DATA_W)
                obs_w[s / DATA_W][s % DATA_W] = wr_bus;
            if (m_rd_valid) obs_rd.push_back(m_rd_data);
            if (m_done) begin
                done_cyc   = cyc;
                done_flags = {master_valid, master_ready, m_busy, m_error};
            end

            // Requester side: next word only on m_wr_req, garbage otherwise.
            if (m_wr_req) begin
                wreq_cnt++;
                if (first_wreq < 0) first_wreq = cyc;
                m_wr_data = (wr_idx < MAX_BEATS) ? t_words[wr_idx] : '0;
                wr_idx++;
            end else begin
                m_wr_data = DATA_W'($urandom);
            end
            m_start     = m_busy ? 1'($urandom) : 1'b0;
            m_mode      = 1'($urandom);
            m_addr      = ADDR_W'($urandom);
            m_burst_len = BURST_W'($urandom);
            slave_ready = (cyc > t_req_wait);

            // Slave side.
            if (sl_active) begin
                rd_bus      = t_words[sl_beat][sl_bit];
                slave_valid = 1'($urandom);
                sl_bit++;
                if (sl_bit == DATA_W) begin
                    sl_active = 0; sl_beat++; sl_gap = 0;
                end
            end else if (master_ready && !t_silent) begin
                if (sl_gap == t_gaps[sl_beat]) begin
                    slave_valid = 1'b1; rd_bus = t_words[sl_beat][0];
                    sl_bit = 1; sl_active = 1;
                end else begin
                    slave_valid = 1'b0; rd_bus = 1'($urandom); sl_gap++;
                end
            end else begin
                slave_valid = t_silent ? 1'b0 : 1'($urandom);
                rd_bus      = 1'($urandom);
            end
        end
        m_start = 1'b0; slave_valid = 1'b0;

        exp_mv   = req_len + ADDR_W;
        exp_done = req_len + ADDR_W + 1;
        if (t_silent) begin
            exp_done += TIMEOUT_CYC;
        end else if (t_mode == MODE_WRITE) begin
            exp_mv   += nb * DATA_W;
            exp_done += nb * DATA_W;
        end else begin
            for (int k = 0; k < nb; k++) exp_done += t_gaps[k] + DATA_W;
        end

        check($sformatf("%s.done_cycle", name), 64'(done_cyc), 64'(exp_done));
        check($sformatf("%s.valid_cycles", name), 64'(mv_cnt), 64'(exp_mv));
        check($sformatf("%s.busy_cycles", name), 64'(busy_cnt), 64'(exp_done - 1));
        check($sformatf("%s.wr_bus_idle", name), 64'(idle_wb + req_noise), 64'd0);
        check($sformatf("%s.addr", name), 64'(obs_addr), 64'(t_addr));
        check($sformatf("%s.done_flags", name), 64'(done_flags), {63'd0, t_silent});
        if (t_mode == MODE_WRITE) begin
            check($sformatf("%s.wr_req_count", name), 64'(wreq_cnt), 64'(nb - 1));
            check($sformatf("%s.ready_in_write", name), 64'(mr_in_write), 64'd0);
            if (nb > 1)
                check($sformatf("%s.first_wr_req", name), 64'(first_wreq),
                      64'(req_len + ADDR_W + DATA_W));
            for (int k = 0; k < nb; k++)
                check($sformatf("%s.wdata%0d", name, k), 64'(obs_w[k]), 64'(t_words[k]));
        end else begin
            check($sformatf("%s.rd_valid_count", name), 64'(obs_rd.size()),
                  t_silent ? 64'd0 : 64'(nb));
            for (int k = 0; k < obs_rd.size() && k < nb; k++)
                check($sformatf("%s.rdata%0d", name, k), 64'(obs_rd[k]), 64'(t_words[k]));
        end
    endtask

    task automatic clear_txn();
        t_silent = 0; t_req_wait = 0;
        for (int k = 0; k < MAX_BEATS; k++) begin
            t_words[k] = DATA_W'($urandom);
            t_gaps[k]  = $urandom_range(0, 3);
        end
    endtask

    initial begin
        #1;
        check("reset.outputs", 64'(all_outputs()), 64'd0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;

        clear_txn();
        t_mode = MODE_WRITE; t_addr = 16'h1234; t_len = '0; t_words[0] = 8'h5A;
        t_gaps[0] = 0;
        run_txn("single_write");

        clear_txn();
        t_mode = MODE_WRITE; t_addr = ADDR_W'($urandom); t_len = 4'd3;
        t_words[0] = 8'hA1; t_words[1] = 8'hB2; t_words[2] = 8'hC3; t_words[3] = 8'hD4;
        run_txn("burst_write");

        clear_txn();
        t_mode = MODE_READ; t_addr = ADDR_W'($urandom); t_len = 4'd1;
        t_words[0] = 8'h3C; t_words[1] = 8'hC3; t_gaps[0] = 0; t_gaps[1] = 2;
        run_txn("burst_read");

        clear_txn();
        t_mode = MODE_WRITE; t_addr = ADDR_W'($urandom); t_len = 4'd1; t_req_wait = 10;
        run_txn("ready_stall");

        // Reset during address bit 7 of a write.
        @(negedge clk);
        m_start = 1'b1; m_mode = MODE_WRITE; m_addr = 16'hFFFF; m_burst_len = '0;
        m_wr_data = 8'hFF; slave_ready = 1'b1;
        @(negedge clk);
        m_start = 1'b0;
        repeat (8) @(negedge clk);
        check("reset_mid.was_active", 64'({m_busy, master_valid, wr_bus}), 64'b111);
        #1 rstn = 1'b0;
        #1 check("reset_mid.outputs", 64'(all_outputs()), 64'd0);
        @(negedge clk);
        check("reset_mid.held", 64'(all_outputs()), 64'd0);
        rstn = 1'b1;

        clear_txn();
        t_mode = MODE_WRITE; t_addr = ADDR_W'($urandom); t_len = 4'd2;
        run_txn("after_reset");

        for (int i = 0; i < 8; i++) begin
            clear_txn();
            t_mode     = (i == 3) ? MODE_WRITE : (i == 4) ? MODE_READ : 1'($urandom);
            t_addr     = ADDR_W'($urandom);
            t_len      = (i == 3 || i == 4) ? '1 : BURST_W'($urandom);
            t_req_wait = $urandom_range(0, 3);
            run_txn($sformatf("rand%0d", i));
        end

`ifdef MASTER_PORT_TIMEOUT_EN
        clear_txn();
        t_mode = MODE_READ; t_addr = ADDR_W'($urandom); t_len = 4'd2; t_silent = 1;
        run_txn("read_timeout");
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks so far", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/master_port_burst.md
Name: master_port_burst

Overview:
- Parametrised next-generation serial bus master port: converts a parallel user request (mode, address, burst length, data) into the bit-serial system-bus protocol (mode line, wr_bus, rd_bus, valid/ready handshakes).
- Sits between a master-side user block and the bus arbiter/interconnect.
- Generalises the fixed 8-bit-data/16-bit-address port to parametric widths and adds multi-beat bursts: the address is sent once, followed by N data beats.

Parameters:
- DATA_W, 8, data word width in bits
- ADDR_W, 16, address width in bits
- BURST_W, 4, width of m_burst_len; beats per transaction = m_burst_len+1 (1..2^BURST_W)
- TIMEOUT_CYC, 64, handshake timeout in cycles (used only with the optional feature)

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- m_start  in  1  request strobe, sampled in IDLE only
- m_mode  in  1  1=write, 0=read
- m_addr  in  ADDR_W  start address
- m_burst_len  in  BURST_W  beats minus one
- m_wr_data  in  DATA_W  write word; beat 0 captured with m_start, later beats captured while m_wr_req=1
- m_wr_req  out  1  one-cycle request for the next write word
- m_rd_data  out  DATA_W  last completed read word
- m_rd_valid  out  1  one-cycle pulse per completed read beat
- m_busy  out  1  transaction in progress
- m_done  out  1  one-cycle completion pulse
- m_error  out  1  timeout flag; pulses with m_done
- mode  out  1  bus mode line, latched m_mode
- wr_bus  out  1  serial master-to-slave line
- rd_bus  in  1  serial slave-to-master line
- master_valid  out  1  master driving valid bits on wr_bus
- slave_ready  in  1  slave accepts request
- master_ready  out  1  master ready to receive read data
- slave_valid  in  1  slave driving rd_bus

Behaviour:
- Reset (async, any state):
  - FSM returns to IDLE.
  - All outputs are 0, including m_rd_data.
  - Counters and shift registers clear.
  - Reset mid-transaction aborts it with no m_done.
- FSM states: IDLE, REQ, ADDR, WDATA, RWAIT, RDATA, DONE.
- IDLE:
  - On m_start=1, latch mode/addr/burst_len, and latch m_wr_data if writing.
  - Go to REQ. m_busy=1 from the next cycle.
- REQ:
  - master_valid=1, mode driven.
  - On slave_ready=1, go to ADDR.
- ADDR:
  - master_valid=1; wr_bus = address bit, LSB first.
  - Lasts exactly ADDR_W cycles, then WDATA if writing, else RWAIT.
- WDATA:
  - master_valid=1; wr_bus = data bit, LSB first; DATA_W cycles per beat.
  - Beats are back-to-back with no gap.
  - During the last bit cycle of each non-final beat, m_wr_req=1; m_wr_data is captured on that edge as the next beat.
  - After the final bit of the final beat, go to DONE.
- RWAIT:
  - master_valid=0, master_ready=1.
  - The cycle slave_valid=1 is sampled, rd_bus is captured as bit 0; go to RDATA.
- RDATA:
  - master_ready=1; samples bits 1..DATA_W-1, one per cycle, LSB first.
  - After the last bit, m_rd_data is updated and m_rd_valid pulses the following cycle.
  - Then RWAIT if beats remain, else DONE. Each read beat requires its own slave_valid handshake.
- DONE:
  - m_done=1 and m_busy=0 for one cycle; return to IDLE.
  - A new m_start can be accepted in the following cycle.
- Boundary conditions:
  - m_start while not in IDLE is ignored.
  - m_burst_len=0 gives a single beat.
  - The beat counter must not wrap for the maximum value 2^BURST_W-1, which gives 2^BURST_W beats.
  - slave_valid/slave_ready outside their waiting states are ignored.
  - wr_bus=0 whenever master_valid=0.
- Latency (write, slave_ready already high): m_start edge → DONE = 1 + 1 + ADDR_W + (len+1)·DATA_W cycles.

Optional Feature:
- Macro: MASTER_PORT_TIMEOUT_EN.
- Defined:
  - A counter runs in REQ and RWAIT, cleared on entry and on a successful handshake.
  - On reaching TIMEOUT_CYC, drop master_valid/master_ready and go to DONE with m_error=1 alongside m_done.
  - No m_rd_valid is emitted for the aborted beat.
- Undefined:
  - The port waits indefinitely.
  - m_error is tied 0; the port is kept for interface stability.

Decomposition:
- Package master_port_pkg:
  - state enum type
  - MODE_READ=1'b0, MODE_WRITE=1'b1
- One natural sub-module, bus_shift_reg:
  - parametrised width
  - load, shift-out LSB-first, shift-in, bit-count/last-bit flag
  - reused for address, write data and read data

Test Plan:
- Single write, DATA_W=8, ADDR_W=16: addr=16'h1234, data=8'h5A, len=0, slave_ready=1 → wr_bus carries 0x1234 then 0x5A LSB-first; master_valid high for 24 bit cycles; m_done after 26 cycles; m_wr_req never asserted.
- Write burst, len=3: words A1,B2,C3,D4 supplied on each m_wr_req → m_wr_req pulses 3 times; 32 contiguous data bits; single address phase.
- Read burst, len=1: slave_valid with rd_bus streams 8'h3C then 8'hC3 → two m_rd_valid pulses with m_rd_data=3C then C3; master_ready low outside RWAIT/RDATA; then m_done.
- slave_ready held low 10 cycles then high → FSM stays in REQ with master_valid=1 and no wr_bus activity; then proceeds normally.
- rstn deasserted mid-ADDR (bit 7) → all outputs 0 immediately; after release, m_start runs a clean transaction; m_start pulsed during busy is ignored.
- With MASTER_PORT_TIMEOUT_EN, TIMEOUT_CYC=64, read with slave_valid never asserted → m_done and m_error pulse together 64 cycles after entering RWAIT; no m_rd_valid.
